interrupt_sequencer: RTL and testbench

INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

---
 rtl/interrupt_sequencer_pkg.sv | 18 +
 rtl/interrupt_sequencer_prio_enc.sv | 23 ++
 rtl/interrupt_sequencer.sv | 128 ++++++++++++
 tb/tb_interrupt_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/interrupt_sequencer_pkg.sv
// Shared definitions for the interrupt sequencer: FSM encoding, line count,
// vector widths and default handler addresses.
package interrupt_sequencer_pkg;

  localparam int unsigned NUM_LINES = 4;
  localparam int unsigned ID_W      = 2;
  localparam int unsigned VEC_W     = 16;

  localparam logic [VEC_W-1:0] VEC_BASE_DEF   = 16'h0200;
  localparam logic [VEC_W-1:0] VEC_STRIDE_DEF = 16'h0010;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/interrupt_sequencer_prio_enc.sv
// Fixed-priority encoder over the request lines; index 0 wins.
// Ports: req    - request vector
//        valid  - at least one request bit set
//        idx    - index of the lowest set bit (0 when none)
module irq_prio_enc
  import interrupt_sequencer_pkg::*;
(
  input  logic [NUM_LINES-1:0] req,
  output logic                 valid,
  output logic [ID_W-1:0]      idx
);

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    idx = '0;
    for (int i = int'(NUM_LINES) - 1; i >= 0; i--) begin
      if (req[i]) idx = ID_W'(i);
    end
  end

  assign valid = |req;

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt sequencer: edge-detects level request lines, holds them pending,
// arbitrates by fixed priority and hands one request at a time to the core.
// Ports: clk, rst (async, active high)
//        irq_in      - level request lines, bit 0 highest priority
//        excp_active - core in exception mode, blocks new requests
//        cfg_we/cfg_data - config write: bit 4 global enable, bits 3:0 line mask
//        irq_ack     - core took the redirect
//        eoi         - handler finished
//        irq_req     - redirect request
//        irq_vector  - handler address, valid while irq_req
//        busy        - a line is in service
//        active_id   - line requested or in service
module interrupt_sequencer
  import interrupt_sequencer_pkg::*;
#(
  parameter logic [15:0] VEC_BASE   = VEC_BASE_DEF,
  parameter logic [15:0] VEC_STRIDE = VEC_STRIDE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  irq_in,
  input  logic        excp_active,
  input  logic        cfg_we,
  input  logic [4:0]  cfg_data,
  input  logic        irq_ack,
  input  logic        eoi,
  output logic        irq_req,
  output logic [15:0] irq_vector,
  output logic        busy,
  output logic [1:0]  active_id
);

  state_t               state, state_d;
  logic [NUM_LINES-1:0] irq_q;
  logic [NUM_LINES-1:0] pending, pending_d;
  logic [NUM_LINES-1:0] mask;
  logic                 gen_en;
  logic [NUM_LINES-1:0] edge_det;
  logic [NUM_LINES-1:0] eligible;
  logic [NUM_LINES-1:0] clr;
  logic                 enc_valid;
  logic [ID_W-1:0]      enc_idx;
  logic                 ack_take;
  logic                 req_d;
  logic [VEC_W-1:0]     vec_d;
  logic                 busy_d;
  logic [ID_W-1:0]      id_d;

  assign edge_det = irq_in & ~irq_q;
  assign eligible = gen_en ? (pending & mask) : '0;

  irq_prio_enc u_prio_enc (
    .req   (eligible),
    .valid (enc_valid),
    .idx   (enc_idx)
  );

  // A new edge on the line being acknowledged re-arms it (set beats clear).
  assign clr       = ack_take ? (NUM_LINES'(1) << active_id) : '0;
  assign pending_d = (pending & ~clr) | edge_det;

  // Next-state and next-output logic; outputs hold unless a transition fires.
  always_comb begin
    state_d  = state;
    req_d    = irq_req;
    vec_d    = irq_vector;
    busy_d   = busy;
    id_d     = active_id;
    ack_take = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enc_valid && !excp_active) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          id_d    = enc_idx;
          vec_d   = VEC_W'(VEC_BASE + VEC_W'(enc_idx) * VEC_STRIDE);
        end
      end
      ST_REQ: begin
        if (irq_ack) begin
          state_d  = ST_SERVICE;
          req_d    = 1'b0;
          busy_d   = 1'b1;
          ack_take = 1'b1;
        end
      end
      ST_SERVICE: begin
        if (eoi) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, request bookkeeping, config and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      irq_q      <= '0;
      pending    <= '0;
      mask       <= '0;
      gen_en     <= 1'b0;
      irq_req    <= 1'b0;
      irq_vector <= '0;
      busy       <= 1'b0;
      active_id  <= '0;
    end else begin
      state      <= state_d;
      irq_q      <= irq_in;
      pending    <= pending_d;
      if (cfg_we) begin
        gen_en <= cfg_data[4];
        mask   <= cfg_data[3:0];
      end
      irq_req    <= req_d;
      irq_vector <= vec_d;
      busy       <= busy_d;
      active_id  <= id_d;
    end
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
module tb_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  irq_in;
  logic        excp_active;
  logic        cfg_we;
  logic [4:0]  cfg_data;
  logic        irq_ack;
  logic        eoi;
  logic        irq_req;
  logic [15:0] irq_vector;
  logic        busy;
  logic [1:0]  active_id;

  typedef struct {
    logic [15:0] vec;
    logic [1:0]  id;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  interrupt_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .irq_in      (irq_in),
    .excp_active (excp_active),
    .cfg_we      (cfg_we),
    .cfg_data    (cfg_data),
    .irq_ack     (irq_ack),
    .eoi         (eoi),
    .irq_req     (irq_req),
    .irq_vector  (irq_vector),
    .busy        (busy),
    .active_id   (active_id)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] id);
    exp_t e;
    e.id  = id;
    e.vec = 16'h0200 + 16'(id) * 16'h0010;
    return e;
  endfunction

  // Wait up to max_cycles edges for irq_req, then compare against the scoreboard.
  task automatic wait_req(input string tag, input int max_cycles);
    exp_t e;
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      if (irq_req === 1'b1) break;
    end
    check({tag, "_req"}, 16'(irq_req), 16'h0001);
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 16'(exp_q.size()), 16'h0001);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_vec"}, irq_vector, e.vec);
      check({tag, "_id"}, 16'(active_id), 16'(e.id));
    end
  endtask

  task automatic do_ack(input string tag);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check({tag, "_ack_busy"}, 16'(busy), 16'h0001);
    check({tag, "_ack_req"}, 16'(irq_req), 16'h0000);
  endtask

  task automatic do_eoi(input string tag);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    check({tag, "_eoi_busy"}, 16'(busy), 16'h0000);
  endtask

  task automatic write_cfg(input logic [4:0] v);
    cfg_we   = 1'b1;
    cfg_data = v;
    tick();
    cfg_we   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; irq_in = '0; excp_active = 1'b0; cfg_we = 1'b0;
    cfg_data = '0; irq_ack = 1'b0; eoi = 1'b0;
    tick(2);
    check("rst_req", 16'(irq_req), 16'h0000);
    check("rst_vec", irq_vector, 16'h0000);
    check("rst_busy", 16'(busy), 16'h0000);
    check("rst_id", 16'(active_id), 16'h0000);
    rst = 1'b0;
    tick();

    // Single request on line 2 with two-cycle latency.
    write_cfg(5'h1F);
    irq_in = 4'b0100;
    exp_q.push_back(mk(2'd2));
    tick();
    check("lat_edge1_req", 16'(irq_req), 16'h0000);
    wait_req("line2", 1);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    check("eoi_in_req_ignored", 16'(irq_req), 16'h0001);
    irq_in = 4'b0000;
    do_ack("line2");
    do_eoi("line2");
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check("ack_in_idle_busy", 16'(busy), 16'h0000);
    check("ack_in_idle_req", 16'(irq_req), 16'h0000);

    // Simultaneous lines 3 and 1: priority, then the waiting line.
    irq_in = 4'b1010;
    exp_q.push_back(mk(2'd1));
    exp_q.push_back(mk(2'd3));
    wait_req("prio_l1", 2);
    do_ack("prio_l1");
    do_eoi("prio_l1");
    wait_req("prio_l3", 2);
    write_cfg(5'h00);
    tick();
    check("hold_req", 16'(irq_req), 16'h0001);
    check("hold_vec", irq_vector, 16'h0230);
    check("hold_id", 16'(active_id), 16'h0003);
    irq_in = 4'b0000;
    do_ack("prio_l3");
    do_eoi("prio_l3");
    write_cfg(5'h1F);

    // Masked line 0 waits until its mask bit is set.
    write_cfg(5'h1E);
    irq_in = 4'b0001;
    tick(3);
    check("masked_req", 16'(irq_req), 16'h0000);
    exp_q.push_back(mk(2'd0));
    write_cfg(5'h1F);
    wait_req("unmask_l0", 2);
    irq_in = 4'b0000;
    do_ack("unmask_l0");
    do_eoi("unmask_l0");

    // Exception mode blocks a pending line 1.
    excp_active = 1'b1;
    irq_in = 4'b0010;
    tick(3);
    check("excp_req", 16'(irq_req), 16'h0000);
    excp_active = 1'b0;
    exp_q.push_back(mk(2'd1));
    wait_req("excp_clear", 1);
    irq_in = 4'b0000;
    do_ack("excp_clear");
    do_eoi("excp_clear");

    // New edge on line 2 coinciding with its ack re-arms it.
    irq_in = 4'b0100;
    exp_q.push_back(mk(2'd2));
    wait_req("rearm_first", 2);
    irq_in = 4'b0000;
    tick();
    irq_in = 4'b0100;
    do_ack("rearm");
    do_eoi("rearm");
    exp_q.push_back(mk(2'd2));
    wait_req("rearm_again", 2);
    irq_in = 4'b0000;
    do_ack("rearm_again");

    // Reset during service with line 3 pending drops everything.
    irq_in = 4'b1000;
    tick();
    check("svc_busy", 16'(busy), 16'h0001);
    rst = 1'b1;
    #1;
    check("arst_req", 16'(irq_req), 16'h0000);
    check("arst_vec", irq_vector, 16'h0000);
    check("arst_busy", 16'(busy), 16'h0000);
    check("arst_id", 16'(active_id), 16'h0000);
    irq_in = 4'b0000;
    tick();
    rst = 1'b0;
    write_cfg(5'h1F);
    tick(4);
    check("post_rst_req", 16'(irq_req), 16'h0000);
    check("post_rst_busy", 16'(busy), 16'h0000);
    check("queue_empty", 16'(exp_q.size()), 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
